// File: rtl/user_request_if.sv
// user_request_if
//   Front end between the user-facing sensors/buttons and the toilet
//   controller.  Every raw input is synchronized and debounced on the ce
//   sampling tick.  A request FSM handshakes presence/seat/spray with the
//   controller.  Configuration buttons toggle level bits while the
//   controller is idle.  Every output is registered.
//
// Ports
//   clk, reset (async, active-high), ce (sampling tick)
//   sns_user, sns_seat, btn_*      raw active-high inputs
//   stt_*                          controller status
//   reg_user_en, reg_toilet_using, reg_spray_en   request levels
//   reg_sp_dr_auto_en, reg_spray_mode,
//   reg_auto_dis_en, reg_de_ur                    configuration levels
//   err_req                        one-cycle pulse on a rejected press

// Per-channel 2-flop synchronizer plus tick-based debouncer.
module urq_deb #(
  parameter int DEB_TICKS = 20,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic i_raw,
  output logic o_deb
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(DEB_TICKS);

  logic             r_meta, r_sync, r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_inc;

  assign w_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_deb  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (ce) begin
        // Any tick that sees agreement restarts the count, so only an
        // uninterrupted run of DEB_TICKS disagreeing ticks flips the level.
        if (r_sync == r_deb) begin
          r_cnt <= '0;
        end else if (w_inc == LIM) begin
          r_deb <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= w_inc;
        end
      end
    end
  end

  assign o_deb = r_deb;
endmodule

module user_request_if #(
  parameter int DEB_TICKS = 20,
  parameter int CNT_W     = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic sns_user,
  input  logic sns_seat,
  input  logic btn_spray,
  input  logic btn_auto,
  input  logic btn_mode,
  input  logic btn_auto_dis,
  input  logic btn_de_ur,
  input  logic stt_ready,
  input  logic stt_using,
  input  logic stt_spraying,
  input  logic stt_drying,
  input  logic stt_discharge,
  output logic reg_user_en,
  output logic reg_toilet_using,
  output logic reg_spray_en,
  output logic reg_sp_dr_auto_en,
  output logic reg_spray_mode,
  output logic reg_auto_dis_en,
  output logic reg_de_ur,
  output logic err_req
);
  // Channel map: 0 user, 1 seat, 2 spray, 3 auto, 4 mode, 5 auto_dis, 6 de_ur
  localparam int NCH = 7;

  localparam logic [2:0] R_IDLE    = 3'd0;
  localparam logic [2:0] R_PRESENT = 3'd1;
  localparam logic [2:0] R_SEATED  = 3'd2;
  localparam logic [2:0] R_SPRAY   = 3'd3;
  localparam logic [2:0] R_DONE    = 3'd4;

  // Config bits {de_ur, auto_dis, mode, auto}
  localparam logic [3:0] CFG_RST = 4'b0101;

  logic [NCH-1:0] w_raw, w_deb, w_press;
  logic [NCH-1:0] r_deb_d;
  logic [2:0]     r_state, w_nxt;
  logic [3:0]     r_cfg;
  logic           r_user_en, r_toilet, r_spray_en, r_err;
  logic           w_busy, w_spray_press, w_cfg_any, w_err;

  assign w_raw = {btn_de_ur, btn_auto_dis, btn_mode, btn_auto,
                  btn_spray, sns_seat, sns_user};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    urq_deb #(.DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) u_deb (
      .clk   (clk),
      .rst   (reset),
      .ce    (ce),
      .i_raw (w_raw[g]),
      .o_deb (w_deb[g])
    );
  end

  // Rising edge of the debounced level only; releases are silent.
  assign w_press       = w_deb & ~r_deb_d;
  assign w_spray_press = w_press[2];
  assign w_cfg_any     = |w_press[6:3];
  assign w_busy        = stt_spraying | stt_drying | stt_discharge;

  // Several rejected presses in one cycle still produce a single pulse.
  assign w_err = (w_spray_press && (r_state != R_SEATED)) ||
                 (w_cfg_any && w_busy);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      R_IDLE:    if (w_deb[0] && stt_ready) w_nxt = R_PRESENT;
      R_PRESENT: if (stt_using)             w_nxt = R_SEATED;
                 else if (!w_deb[0])        w_nxt = R_IDLE;
      R_SEATED:  if (w_spray_press)         w_nxt = R_SPRAY;
      R_SPRAY:   if (!stt_using)            w_nxt = R_DONE;
      R_DONE:    if (!w_deb[1] && stt_ready) w_nxt = R_IDLE;
      default:                              w_nxt = R_IDLE;
    endcase
  end

  // Request levels are decoded from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= R_IDLE;
      r_deb_d    <= '0;
      r_cfg      <= CFG_RST;
      r_user_en  <= 1'b0;
      r_toilet   <= 1'b0;
      r_spray_en <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_deb_d    <= w_deb;
      r_user_en  <= (w_nxt == R_PRESENT);
      r_spray_en <= (w_nxt == R_SPRAY);
      r_toilet   <= w_deb[1];
      r_err      <= w_err;
      if (!w_busy) r_cfg <= r_cfg ^ w_press[6:3];
    end
  end

  assign reg_user_en       = r_user_en;
  assign reg_toilet_using  = r_toilet;
  assign reg_spray_en      = r_spray_en;
  assign reg_sp_dr_auto_en = r_cfg[0];
  assign reg_spray_mode    = r_cfg[1];
  assign reg_auto_dis_en   = r_cfg[2];
  assign reg_de_ur         = r_cfg[3];
  assign err_req           = r_err;
endmodule

// File: tb/tb_user_request_if.sv
module tb_user_request_if;
  logic clk = 1'b0;
  logic reset, ce, ce1, seat1;
  logic sns_user, sns_seat, btn_spray, btn_auto, btn_mode, btn_auto_dis, btn_de_ur;
  logic stt_ready, stt_using, stt_spraying, stt_drying, stt_discharge;
  logic user_en, toilet, spray_en, auto_en, mode, ad_en, de_ur, err;
  logic d1_user_en, d1_toilet, d1_spray_en, d1_auto_en, d1_mode, d1_ad_en, d1_de_ur, d1_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic       sel;   // 0: main DUT vector, 1: DEB_TICKS=1 instance seat level
    logic [7:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  user_request_if dut (
    .clk(clk), .reset(reset), .ce(ce),
    .sns_user(sns_user), .sns_seat(sns_seat), .btn_spray(btn_spray),
    .btn_auto(btn_auto), .btn_mode(btn_mode), .btn_auto_dis(btn_auto_dis),
    .btn_de_ur(btn_de_ur), .stt_ready(stt_ready), .stt_using(stt_using),
    .stt_spraying(stt_spraying), .stt_drying(stt_drying),
    .stt_discharge(stt_discharge),
    .reg_user_en(user_en), .reg_toilet_using(toilet), .reg_spray_en(spray_en),
    .reg_sp_dr_auto_en(auto_en), .reg_spray_mode(mode),
    .reg_auto_dis_en(ad_en), .reg_de_ur(de_ur), .err_req(err)
  );

  user_request_if #(.DEB_TICKS(1)) dut1 (
    .clk(clk), .reset(reset), .ce(ce1),
    .sns_user(sns_user), .sns_seat(seat1), .btn_spray(btn_spray),
    .btn_auto(btn_auto), .btn_mode(btn_mode), .btn_auto_dis(btn_auto_dis),
    .btn_de_ur(btn_de_ur), .stt_ready(stt_ready), .stt_using(stt_using),
    .stt_spraying(stt_spraying), .stt_drying(stt_drying),
    .stt_discharge(stt_discharge),
    .reg_user_en(d1_user_en), .reg_toilet_using(d1_toilet),
    .reg_spray_en(d1_spray_en), .reg_sp_dr_auto_en(d1_auto_en),
    .reg_spray_mode(d1_mode), .reg_auto_dis_en(d1_ad_en),
    .reg_de_ur(d1_de_ur), .err_req(d1_err)
  );

  // Expected vector order: {user_en, toilet, spray_en, auto, mode, auto_dis, de_ur, err}
  function automatic logic [7:0] mk(input logic u, t, s, a, m, ad, de, e);
    return {u, t, s, a, m, ad, de, e};
  endfunction

  task automatic push(input string tag, input logic sel, input logic [7:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.v = v;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    logic [7:0] obs;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty got %0d entries want >0", sb.size());
    end else begin
      e = sb.pop_front();
      obs = e.sel ? {7'd0, d1_toilet}
                  : {user_en, toilet, spray_en, auto_en, mode, ad_en, de_ur, err};
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s got %b want %b", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic clk1();
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      ce = 1'b1; @(negedge clk);
      ce = 1'b0; @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; ce1 = 1'b0; seat1 = 1'b0;
    sns_user = 0; sns_seat = 0; btn_spray = 0; btn_auto = 0; btn_mode = 0;
    btn_auto_dis = 0; btn_de_ur = 0;
    stt_ready = 0; stt_using = 0; stt_spraying = 0; stt_drying = 0; stt_discharge = 0;
    settle();
    push("reset_state", 0, mk(0,0,0,1,0,1,0,0)); chk();
    reset = 1'b0;

    // DEB_TICKS=1: one tick accepts the level; without ce nothing moves.
    seat1 = 1'b1; settle();
    push("d1_one_tick", 1, 8'd1);
    ce1 = 1'b1; clk1(); ce1 = 1'b0; clk1(); chk();
    seat1 = 1'b0;
    push("d1_no_ce", 1, 8'd1);
    repeat (50) clk1(); chk();
    push("d1_tick_back", 1, 8'd0);
    ce1 = 1'b1; clk1(); ce1 = 1'b0; clk1(); chk();

    // Presence handshake.
    stt_ready = 1'b1; sns_user = 1'b1; sns_seat = 1'b1; settle();
    push("user_tick19", 0, mk(0,0,0,1,0,1,0,0)); ticks(19); chk();
    push("user_en_tick20", 0, mk(1,1,0,1,0,1,0,0)); ticks(1); chk();
    push("user_hold30", 0, mk(1,1,0,1,0,1,0,0)); ticks(10); chk();
    stt_using = 1'b1;
    push("ack_drop", 0, mk(0,1,0,1,0,1,0,0)); clk1(); chk();

    // 10-tick spray glitch in R_SEATED is ignored.
    btn_spray = 1'b1; settle(); ticks(10);
    btn_spray = 1'b0; settle();
    push("spray_glitch", 0, mk(0,1,0,1,0,1,0,0)); ticks(12); chk();

    // Real spray press.
    btn_spray = 1'b1; settle();
    push("spray_tick19", 0, mk(0,1,0,1,0,1,0,0)); ticks(19); chk();
    push("spray_en", 0, mk(0,1,1,1,0,1,0,0)); ticks(1); chk();
    push("spray_hold25", 0, mk(0,1,1,1,0,1,0,0)); ticks(5); chk();
    btn_spray = 1'b0; settle();
    push("spray_release", 0, mk(0,1,1,1,0,1,0,0)); ticks(20); chk();
    stt_using = 1'b0;
    push("spray_done", 0, mk(0,1,0,1,0,1,0,0)); clk1(); chk();

    // Leave the seat: R_DONE back to R_IDLE.
    sns_user = 1'b0; sns_seat = 1'b0; settle();
    push("leave_idle", 0, mk(0,0,0,1,0,1,0,0)); ticks(20); chk();

    // Spray press in R_IDLE is rejected.
    btn_spray = 1'b1; settle();
    push("spray_idle_err", 0, mk(0,0,0,1,0,1,0,1)); ticks(20); chk();
    push("spray_idle_1clk", 0, mk(0,0,0,1,0,1,0,0)); clk1(); chk();
    btn_spray = 1'b0; settle(); ticks(20);

    // Mode press while drying is rejected, then accepted when idle.
    stt_drying = 1'b1; btn_mode = 1'b1; settle();
    push("mode_busy_err", 0, mk(0,0,0,1,0,1,0,1)); ticks(20); chk();
    push("mode_busy_1clk", 0, mk(0,0,0,1,0,1,0,0)); clk1(); chk();
    btn_mode = 1'b0; settle(); ticks(20);
    stt_drying = 1'b0; stt_using = 1'b1; btn_mode = 1'b1; settle();
    push("mode_toggle", 0, mk(0,0,0,1,1,1,0,0)); ticks(20); chk();
    btn_mode = 1'b0; settle(); ticks(20); stt_using = 1'b0;

    // Simultaneous accepted toggles.
    btn_auto = 1'b1; btn_auto_dis = 1'b1; btn_de_ur = 1'b1; settle();
    push("multi_toggle", 0, mk(0,0,0,0,1,0,1,0)); ticks(20); chk();
    btn_auto = 1'b0; btn_auto_dis = 1'b0; btn_de_ur = 1'b0; settle(); ticks(20);

    // Simultaneous rejected presses give one err pulse, no toggles.
    stt_spraying = 1'b1; btn_auto = 1'b1; btn_mode = 1'b1; btn_spray = 1'b1; settle();
    push("multi_err", 0, mk(0,0,0,0,1,0,1,1)); ticks(20); chk();
    push("multi_err_1clk", 0, mk(0,0,0,0,1,0,1,0)); clk1(); chk();
    btn_auto = 1'b0; btn_mode = 1'b0; btn_spray = 1'b0; settle(); ticks(20);
    stt_spraying = 1'b0;

    // Walk to R_SPRAY again, then reset mid-spray.
    sns_user = 1'b1; sns_seat = 1'b1; settle();
    push("s2_present", 0, mk(1,1,0,0,1,0,1,0)); ticks(20); chk();
    stt_using = 1'b1;
    push("s2_seated", 0, mk(0,1,0,0,1,0,1,0)); clk1(); chk();
    btn_spray = 1'b1; settle();
    push("s2_spray", 0, mk(0,1,1,0,1,0,1,0)); ticks(20); chk();
    reset = 1'b1; #2;
    push("reset_in_spray", 0, mk(0,0,0,1,0,1,0,0)); chk();
    stt_using = 1'b0; clk1(); clk1();
    reset = 1'b0; settle();

    // Inputs still high at release: one event only after a full debounce.
    push("post_rst_tick19", 0, mk(0,0,0,1,0,1,0,0)); ticks(19); chk();
    push("post_rst_event", 0, mk(1,1,0,1,0,1,0,1)); ticks(1); chk();
    push("post_rst_1clk", 0, mk(1,1,0,1,0,1,0,0)); clk1(); chk();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/user_request_if.md
USER_REQUEST_IF -- requirements
Module: user_request_if

Interface
REQ-001 Parameter: DEB_TICKS, 20, number of consecutive ce ticks a raw input must hold a new level before it is accepted (range 1..31).
REQ-002 Parameter: CNT_W, 5, width of each debounce counter.
REQ-003 Ports: clk  in  1  system clock (1 MHz); one clock domain.
REQ-004 Ports: reset  in  1  asynchronous, active-high reset.
REQ-005 Ports: ce  in  1  single-cycle sampling tick for debouncers.
REQ-006 Ports: sns_user, sns_seat, btn_spray, btn_auto, btn_mode, btn_auto_dis, btn_de_ur  in  1 each  raw asynchronous presence sensor, seat sensor and buttons, active-high.
REQ-007 Ports: stt_ready, stt_using, stt_spraying, stt_drying, stt_discharge  in  1 each  controller status.
REQ-008 Ports: reg_user_en, reg_toilet_using, reg_spray_en  out  1 each  request levels to the controller.
REQ-009 Ports: reg_sp_dr_auto_en, reg_spray_mode, reg_auto_dis_en, reg_de_ur  out  1 each  configuration levels to the controller.
REQ-010 Ports: err_req  out  1  one-cycle pulse on any rejected press.

Function
REQ-011 Each raw input SHALL pass a 2-flop synchronizer; synchronized value is sync_x.
REQ-012 Each channel SHALL hold a debounced level deb_x and a CNT_W-bit counter: on ce, counter clears if sync_x==deb_x, else increments; when it would reach DEB_TICKS, deb_x <= sync_x and counter clears.
REQ-013 Counters SHALL not advance without ce; a glitch shorter than DEB_TICKS ticks SHALL not change deb_x.
REQ-014 A press event SHALL be a one-cycle pulse on the 0->1 transition of deb_x for each button; releases generate no event.
REQ-015 reg_toilet_using SHALL equal deb_seat, registered.
REQ-016 Request FSM states: R_IDLE, R_PRESENT, R_SEATED, R_SPRAY, R_DONE.
REQ-017 R_IDLE -> R_PRESENT when deb_user=1 and stt_ready=1; reg_user_en=1 in R_PRESENT only.
REQ-018 R_PRESENT -> R_SEATED when stt_using=1 (handshake ack); -> R_IDLE if deb_user=0 before ack.
REQ-019 R_SEATED: spray press -> R_SPRAY; reg_spray_en=1 in R_SPRAY, held until stt_using=0, then -> R_DONE.
REQ-020 R_DONE -> R_IDLE when deb_seat=0 and stt_ready=1; no requests issued in R_DONE.
REQ-021 Spray press outside R_SEATED SHALL be ignored and pulse err_req.
REQ-022 btn_auto, btn_mode, btn_auto_dis, btn_de_ur presses SHALL toggle their reg_ bit only when stt_spraying, stt_drying, stt_discharge are all 0; otherwise no change and err_req pulses.
REQ-023 Simultaneous events in one cycle: all accepted toggles apply together; err_req is a single pulse regardless of count.
REQ-024 All outputs SHALL be registered; press-to-output latency is exactly 1 clk after the press event cycle.
REQ-025 Illegal FSM encoding SHALL return to R_IDLE next cycle.

Reset
REQ-026 reset=1 SHALL immediately force: FSM R_IDLE, all synchronizers, deb_x and counters 0, reg_user_en/reg_toilet_using/reg_spray_en 0, reg_sp_dr_auto_en 1, reg_spray_mode 0, reg_auto_dis_en 1, reg_de_ur 0, err_req 0.
REQ-027 Reset asserted mid-sequence (any state) SHALL abandon the request; after release no press event fires for inputs already high until they debounce (a level already high at release produces one event after DEB_TICKS ticks).

Verification
REQ-028 sns_user high 30 ticks, stt_ready=1 -> reg_user_en=1 after tick 20 +1 clk; stt_using=1 -> reg_user_en=0 next clk.
REQ-029 btn_spray 10-tick glitch -> no event; held 25 ticks in R_SEATED -> reg_spray_en=1 until stt_using=0.
REQ-030 btn_mode press with stt_drying=1 -> reg_spray_mode unchanged, err_req one pulse; same press with stt_using=1 -> reg_spray_mode toggles 0->1.
REQ-031 btn_spray press in R_IDLE -> err_req=1 for one clk, FSM stays R_IDLE.
REQ-032 reset asserted in R_SPRAY -> reg_spray_en=0 same cycle, reg_sp_dr_auto_en=1, FSM R_IDLE.
REQ-033 DEB_TICKS=1: input held one tick -> deb_x updates on that tick; ce held 0 -> no update for any input duration.
